// File: rtl/kgp_pc_pkg.sv
// Next-PC command codes shared between control_unit and the fetch stage,
// plus the target-address helpers both sides agree on.
package kgp_pc_pkg;

  localparam int PC_CTRL_W = 4;
  typedef logic [PC_CTRL_W-1:0] pc_ctrl_t;

  localparam pc_ctrl_t PC_SEQ  = 4'h0;
  localparam pc_ctrl_t PC_BREL = 4'h1;
  localparam pc_ctrl_t PC_BABS = 4'h2;
  localparam pc_ctrl_t PC_JR   = 4'h3;
  localparam pc_ctrl_t PC_CALL = 4'h4;
  localparam pc_ctrl_t PC_RET  = 4'h5;
  localparam pc_ctrl_t PC_HALT = 4'h6;

  function automatic logic [31:0] brel_target(input logic [31:0] pc_plus4,
                                              input logic [15:0] imm16);
    return pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

  // Absolute jumps stay inside the 256 MB region of the following instruction.
  function automatic logic [31:0] babs_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] target26);
    return {pc_plus4[31:28], target26, 2'b00};
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// LIFO of return addresses; the occupancy count doubles as the write pointer.
// Storage is left unreset, only the count clears.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] top_idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign top_idx = count_q[AW-1:0] - AW'(1);
  assign dout    = mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    if (push && !full)
      count_d = count_q + CW'(1);
    else if (pop && !empty)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem_q[count_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, next-PC selection from control_unit's command,
// return-address stack for CALL/RET, and sticky halt/error status.
module pc_fetch_unit
  import kgp_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 10,
  parameter int          RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [PC_CTRL_W-1:0]         pc_control,
  input  logic [31:0]                  instruction,
  input  logic [31:0]                  reg_target,
  output logic [31:0]                  pc,
  output logic [31:0]                  pc_plus4,
  output logic [IMEM_AW-1:0]           imem_addr,
  output logic                         halted,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic                         illegal_pc_control,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        illegal_q, illegal_d;
  logic        ras_push, ras_pop, ras_full, ras_empty;
  logic [31:0] ras_dout;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^instruction[31:26];

  assign pc                 = pc_q;
  assign pc_plus4           = pc_q + 32'd4;
  assign imem_addr          = pc_q[IMEM_AW+1:2];
  assign halted             = halted_q;
  assign ras_overflow       = ovf_q;
  assign ras_underflow      = unf_q;
  assign illegal_pc_control = illegal_q;

  return_addr_stack #(.DEPTH(RAS_DEPTH), .W(32)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus4),
    .dout  (ras_dout),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Stall and halt both freeze everything, and they outrank every command.
  always_comb begin
    pc_d      = pc_q;
    halted_d  = halted_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    illegal_d = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    if (!stall && !halted_q) begin
      case (pc_control)
        PC_SEQ:  pc_d = pc_plus4;
        PC_BREL: pc_d = brel_target(pc_plus4, instruction[15:0]);
        PC_BABS: pc_d = babs_target(pc_plus4, instruction[25:0]);
        PC_JR:   pc_d = reg_target & ~32'h3;
        PC_CALL: begin
          ras_push = 1'b1;
          if (ras_full) ovf_d = 1'b1;
          pc_d = babs_target(pc_plus4, instruction[25:0]);
        end
        PC_RET: begin
          if (ras_empty) begin
            unf_d = 1'b1;
            pc_d  = pc_plus4;
          end else begin
            ras_pop = 1'b1;
            pc_d    = ras_dout;
          end
        end
        PC_HALT: halted_d = 1'b1;
        default: begin
          pc_d      = pc_plus4;
          illegal_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a queue-based reference model checked every
// cycle, plus literal expectations taken straight from the command definitions.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          IMEM_AW   = 10;
  localparam int          RAS_DEPTH = 8;
  localparam int          CW        = $clog2(RAS_DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              stall;
  logic [3:0]        pc_control;
  logic [31:0]       instruction;
  logic [31:0]       reg_target;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic [IMEM_AW-1:0] imem_addr;
  logic              halted;
  logic              ras_overflow;
  logic              ras_underflow;
  logic              illegal_pc_control;
  logic [CW-1:0]     ras_count;

  int n_checks = 0;
  int n_err    = 0;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .pc_control         (pc_control),
    .instruction        (instruction),
    .reg_target         (reg_target),
    .pc                 (pc),
    .pc_plus4           (pc_plus4),
    .imem_addr          (imem_addr),
    .halted             (halted),
    .ras_overflow       (ras_overflow),
    .ras_underflow      (ras_underflow),
    .illegal_pc_control (illegal_pc_control),
    .ras_count          (ras_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_halted, m_ovf, m_unf, m_ill;

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_ras    = {};
    m_halted = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_ill    = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] p4;
    logic [31:0] abs_t;
    int          off;
    p4    = m_pc + 32'd4;
    abs_t = (p4 & 32'hF000_0000) + 32'(instruction[25:0]) * 4;
    off   = int'($signed(instruction[15:0]));
    m_ill = 1'b0;
    if (stall || m_halted) return;
    case (pc_control)
      4'h0: m_pc = p4;
      4'h1: m_pc = p4 + 32'(off * 4);
      4'h2: m_pc = abs_t;
      4'h3: m_pc = reg_target - (reg_target % 4);
      4'h4: begin
        if (m_ras.size() == RAS_DEPTH) m_ovf = 1'b1;
        else m_ras.push_back(p4);
        m_pc = abs_t;
      end
      4'h5: begin
        if (m_ras.size() == 0) begin
          m_unf = 1'b1;
          m_pc  = p4;
        end else begin
          m_pc = m_ras.pop_back();
        end
      end
      4'h6: m_halted = 1'b1;
      default: begin
        m_pc  = p4;
        m_ill = 1'b1;
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("model_pc",        pc,                        m_pc);
      check("model_pc_plus4",  pc_plus4,                  m_pc + 32'd4);
      check("model_imem_addr", 32'(imem_addr),            (m_pc / 4) % (1 << IMEM_AW));
      check("model_halted",    32'(halted),               32'(m_halted));
      check("model_ovf",       32'(ras_overflow),         32'(m_ovf));
      check("model_unf",       32'(ras_underflow),        32'(m_unf));
      check("model_illegal",   32'(illegal_pc_control),   32'(m_ill));
      check("model_ras_count", 32'(ras_count),            32'(m_ras.size()));
    end
  end

  // ---------------- driver ----------------
  task automatic cmd(input logic [3:0] code, input logic [31:0] instr,
                     input logic [31:0] rt, input logic st);
    pc_control  = code;
    instruction = instr;
    reg_target  = rt;
    stall       = st;
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    cmd(4'h3, 32'h0, addr, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    pc_control  = 4'h0;
    instruction = 32'h0;
    reg_target  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc",    pc,                    32'h0);
    check("reset_count", 32'(ras_count),        32'd0);
    check("reset_flags", {28'h0, halted, ras_overflow, ras_underflow, illegal_pc_control}, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // 1: sequential fetch
    check("seq_pc0",   pc,               32'h0);
    check("seq_imem0", 32'(imem_addr),   32'd0);
    for (int i = 1; i <= 3; i++) begin
      cmd(4'h0, 32'h0, 32'h0, 1'b0);
      check("seq_pc",   pc,             32'(4 * i));
      check("seq_imem", 32'(imem_addr), 32'(i));
    end

    // 2: relative branches, JR low bits forced to zero
    jump_to(32'h23);
    check("jr_align", pc, 32'h20);
    cmd(4'h1, 32'h0000_FFFE, 32'h0, 1'b0);
    check("brel_neg", pc, 32'h1C);
    jump_to(32'h20);
    cmd(4'h1, 32'h0000_0003, 32'h0, 1'b0);
    check("brel_pos", pc, 32'h30);
    cmd(4'h2, 32'h0000_0040, 32'h0, 1'b0);
    check("babs", pc, 32'h100);

    // 3: call / return
    jump_to(32'h40);
    cmd(4'h4, 32'h0000_0100, 32'h0, 1'b0);
    check("call_pc",    pc,             32'h400);
    check("call_count", 32'(ras_count), 32'd1);
    cmd(4'h5, 32'h0, 32'h0, 1'b0);
    check("ret_pc",     pc,             32'h44);
    check("ret_count",  32'(ras_count), 32'd0);

    // 4: underflow is sticky
    jump_to(32'h10);
    cmd(4'h5, 32'h0, 32'h0, 1'b0);
    check("unf_pc",   pc,                  32'h14);
    check("unf_flag", 32'(ras_underflow),  32'd1);
    cmd(4'h0, 32'h0, 32'h0, 1'b0);
    check("unf_sticky", 32'(ras_underflow), 32'd1);
    check("unf_pc2",    pc,                 32'h18);

    // 5: fill the stack, overflow once, unwind
    for (int k = 0; k < RAS_DEPTH; k++)
      cmd(4'h4, 32'h100 + 32'(16 * k), 32'h0, 1'b0);
    check("full_count", 32'(ras_count),    32'(RAS_DEPTH));
    check("full_noovf", 32'(ras_overflow), 32'd0);
    cmd(4'h4, 32'h0000_0200, 32'h0, 1'b0);
    check("ovf_pc",    pc,                 32'h800);
    check("ovf_flag",  32'(ras_overflow),  32'd1);
    check("ovf_count", 32'(ras_count),     32'(RAS_DEPTH));
    cmd(4'h5, 32'h0, 32'h0, 1'b0);
    check("unwind_first", pc, 32'h584);
    for (int k = 1; k < RAS_DEPTH; k++)
      cmd(4'h5, 32'h0, 32'h0, 1'b0);
    check("unwind_last",  pc,             32'h1C);
    check("unwind_count", 32'(ras_count), 32'd0);

    // 6: stall priority, illegal pulse, halt, async reset
    cmd(4'h4, 32'h0000_0100, 32'h0, 1'b1);
    check("stall_pc",    pc,             32'h1C);
    check("stall_count", 32'(ras_count), 32'd0);
    cmd(4'h6, 32'h0, 32'h0, 1'b1);
    check("stall_halt", 32'(halted), 32'd0);
    cmd(4'hF, 32'h0, 32'h0, 1'b0);
    check("illegal_pc",    pc,                       32'h20);
    check("illegal_pulse", 32'(illegal_pc_control),  32'd1);
    cmd(4'h0, 32'h0, 32'h0, 1'b0);
    check("illegal_clear", 32'(illegal_pc_control),  32'd0);
    cmd(4'h6, 32'h0, 32'h0, 1'b0);
    check("halt_pc",   pc,           32'h24);
    check("halt_flag", 32'(halted),  32'd1);
    cmd(4'hF, 32'h0, 32'h0, 1'b0);
    check("halt_ignore_pc",  pc,                      32'h24);
    check("halt_ignore_ill", 32'(illegal_pc_control), 32'd0);
    cmd(4'h0, 32'h0, 32'h0, 1'b0);
    check("halt_hold", pc, 32'h24);
    check("ovf_still", 32'(ras_overflow), 32'd1);

    #2;
    rst = 1'b0;
    #1;
    check("async_rst_pc",    pc,             RESET_PC);
    check("async_rst_count", 32'(ras_count), 32'd0);
    check("async_rst_flags", {28'h0, halted, ras_overflow, ras_underflow, illegal_pc_control}, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    cmd(4'h0, 32'h0, 32'h0, 1'b0);
    check("post_rst_seq", pc, 32'h4);
    cmd(4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
